// File: rtl/spi_frame_ctrl.sv
// Receives a 128-bit pose/colour frame over SPI in the clk domain and validates it.
// Valid frames wait in a pending register and move to the outputs on the next frame_start pulse.
module spi_frame_ctrl #(
    parameter logic [7:0]  HEADER         = 8'hA5,
    parameter int unsigned X_MAX          = 640,
    parameter int unsigned Y_MAX          = 480,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sck,
    input  logic       sdi,
    input  logic       load,
    input  logic       frame_start,
    output logic       sdo,
    output logic [9:0] x_1,
    output logic [9:0] y_1,
    output logic [9:0] x_2,
    output logic [9:0] y_2,
    output logic [9:0] x_3,
    output logic [9:0] y_3,
    output logic [9:0] x_4,
    output logic [9:0] y_4,
    output logic [3:0] r,
    output logic [3:0] g,
    output logic [3:0] b,
    output logic       frame_valid,
    output logic       busy,
    output logic [7:0] drop_cnt,
    output logic [1:0] last_err
);

    localparam int unsigned FRAME_W = 128;
    localparam int unsigned CNT_W   = 7;
    localparam int unsigned PAY_W   = 92;
    localparam int unsigned CRD_W   = 10;
    localparam int unsigned CMP_W   = CRD_W + 1;
    localparam int unsigned TMR_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned DROP_W  = 8;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_HEADER  = 2'd1;
    localparam logic [1:0] ERR_RANGE   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    state_t               state;
    logic [1:0]           sck_sync;
    logic [1:0]           sdi_sync;
    logic [1:0]           load_sync;
    logic                 sck_d;
    logic [FRAME_W-1:0]   shift_reg;
    logic [CNT_W-1:0]     bit_cnt;
    logic [TMR_W-1:0]     timer;
    logic                 pending;
    logic [PAY_W-1:0]     pend_data;
    logic [PAY_W-1:0]     out_data;

    logic rise_c;
    logic fall_c;
    logic hdr_ok_c;
    logic range_ok_c;
    logic timeout_c;
    logic drop_c;

    assign rise_c = sck_sync[1] & ~sck_d;
    assign fall_c = ~sck_sync[1] & sck_d;
    assign busy   = (state == SHIFT);

    assign {x_1, y_1, x_2, y_2, x_3, y_3, x_4, y_4, r, g, b} = out_data;

    // Frame validation on the completed shift register, used only in CHECK.
    always_comb begin
        hdr_ok_c   = (shift_reg[127:120] == HEADER);
        range_ok_c = 1'b1;
        for (int j = 0; j < 4; j++) begin
            if ({1'b0, shift_reg[91-20*j -: CRD_W]} >= CMP_W'(X_MAX) ||
                {1'b0, shift_reg[81-20*j -: CRD_W]} >= CMP_W'(Y_MAX)) begin
                range_ok_c = 1'b0;
            end
        end
    end

    // Any discard event: timeout, bad frame, or a valid frame overwriting an uncommitted one.
    always_comb begin
        timeout_c = (state == SHIFT) && !load_sync[1] && !rise_c &&
                    (timer == TMR_W'(TIMEOUT_CYCLES - 1));
        drop_c    = timeout_c ||
                    ((state == CHECK) &&
                     (!hdr_ok_c || !range_ok_c || (pending && !frame_start)));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync  <= '0;
            sdi_sync  <= '0;
            load_sync <= '0;
            sck_d     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[0], sck};
            sdi_sync  <= {sdi_sync[0], sdi};
            load_sync <= {load_sync[0], load};
            sck_d     <= sck_sync[1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            timer       <= '0;
            pending     <= 1'b0;
            pend_data   <= '0;
            out_data    <= '0;
            sdo         <= 1'b0;
            frame_valid <= 1'b0;
            drop_cnt    <= '0;
            last_err    <= ERR_NONE;
        end else begin
            frame_valid <= 1'b0;

            if (fall_c) begin
                sdo <= shift_reg[FRAME_W-1];
            end

            if (drop_c && (drop_cnt != {DROP_W{1'b1}})) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end

            // Commit takes the frame pending before this cycle; a frame set in CHECK now waits.
            if (frame_start && pending) begin
                out_data    <= pend_data;
                frame_valid <= 1'b1;
                pending     <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (load_sync[1]) begin
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                        timer     <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (load_sync[1]) begin
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                        timer     <= '0;
                    end else if (rise_c) begin
                        shift_reg <= {shift_reg[FRAME_W-2:0], sdi_sync[1]};
                        bit_cnt   <= bit_cnt + CNT_W'(1);
                        timer     <= '0;
                        if (bit_cnt == {CNT_W{1'b1}}) begin
                            state <= CHECK;
                        end
                    end else if (timeout_c) begin
                        last_err <= ERR_TIMEOUT;
                        state    <= IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                CHECK: begin
                    state <= IDLE;
                    if (!hdr_ok_c) begin
                        last_err <= ERR_HEADER;
                    end else if (!range_ok_c) begin
                        last_err <= ERR_RANGE;
                    end else begin
                        pend_data <= shift_reg[PAY_W-1:0];
                        pending   <= 1'b1;
                        last_err  <= ERR_NONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Scoreboard bench for spi_frame_ctrl: random and directed SPI frames against a frame-level model.
module tb_spi_frame_ctrl;

    localparam logic [7:0]  HEADER         = 8'hA5;
    localparam int unsigned X_MAX          = 640;
    localparam int unsigned Y_MAX          = 480;
    localparam int unsigned TIMEOUT_CYCLES = 4096;

    typedef struct packed {
        logic [9:0] x1, y1, x2, y2, x3, y3, x4, y4;
        logic [3:0] r, g, b;
    } frame_t;

    logic       clk = 1'b0;
    logic       reset_n, sck, sdi, load, frame_start;
    logic       sdo, frame_valid, busy;
    logic [9:0] x_1, y_1, x_2, y_2, x_3, y_3, x_4, y_4;
    logic [3:0] r, g, b;
    logic [7:0] drop_cnt;
    logic [1:0] last_err;

    spi_frame_ctrl #(
        .HEADER(HEADER), .X_MAX(X_MAX), .Y_MAX(Y_MAX), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sck(sck), .sdi(sdi), .load(load),
        .frame_start(frame_start), .sdo(sdo),
        .x_1(x_1), .y_1(y_1), .x_2(x_2), .y_2(y_2),
        .x_3(x_3), .y_3(y_3), .x_4(x_4), .y_4(y_4),
        .r(r), .g(g), .b(b), .frame_valid(frame_valid), .busy(busy),
        .drop_cnt(drop_cnt), .last_err(last_err)
    );

    always #5 clk = ~clk;

    int     n_chk  = 0;
    int     n_pass = 0;
    frame_t exp_q[$];

    // Frame-level reference state
    frame_t     m_pend, m_out;
    bit         m_pending;
    int         m_drop;
    logic [1:0] m_err;
    logic       m_sdo;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit in_range(input frame_t f);
        return (32'(f.x1) < X_MAX) && (32'(f.y1) < Y_MAX) &&
               (32'(f.x2) < X_MAX) && (32'(f.y2) < Y_MAX) &&
               (32'(f.x3) < X_MAX) && (32'(f.y3) < Y_MAX) &&
               (32'(f.x4) < X_MAX) && (32'(f.y4) < Y_MAX);
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        f.x1 = 10'($urandom_range(0, X_MAX-1)); f.y1 = 10'($urandom_range(0, Y_MAX-1));
        f.x2 = 10'($urandom_range(0, X_MAX-1)); f.y2 = 10'($urandom_range(0, Y_MAX-1));
        f.x3 = 10'($urandom_range(0, X_MAX-1)); f.y3 = 10'($urandom_range(0, Y_MAX-1));
        f.x4 = 10'($urandom_range(0, X_MAX-1)); f.y4 = 10'($urandom_range(0, Y_MAX-1));
        f.r  = 4'($urandom); f.g = 4'($urandom); f.b = 4'($urandom);
        return f;
    endfunction

    function automatic frame_t outputs_now();
        frame_t f;
        f = {x_1, y_1, x_2, y_2, x_3, y_3, x_4, y_4, r, g, b};
        return f;
    endfunction

    task automatic count_drop();
        if (m_drop < 255) m_drop++;
    endtask

    // Load pulse, then nbits MSB-first with sck at 1/8 of clk; ignored bits are random.
    task automatic send_bits(input frame_t f, input logic [7:0] hdr, input int nbits);
        logic [127:0] v;
        v = {hdr, 28'($urandom), f};
        @(posedge clk); #1 load = 1'b1;
        repeat (4) @(posedge clk);
        #1 load = 1'b0;
        repeat (4) @(posedge clk);
        for (int i = 0; i < nbits; i++) begin
            #1 sck = 1'b0; sdi = v[127-i];
            repeat (4) @(posedge clk);
            #1 sck = 1'b1;
            repeat (4) @(posedge clk);
        end
        #1 sck = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    task automatic send_frame(input frame_t f, input logic [7:0] hdr);
        send_bits(f, hdr, 128);
        m_sdo = hdr[7];
        if (hdr != HEADER) begin
            m_err = 2'd1; count_drop();
        end else if (!in_range(f)) begin
            m_err = 2'd2; count_drop();
        end else begin
            if (m_pending) count_drop();
            m_pending = 1'b1; m_pend = f; m_err = 2'd0;
        end
    endtask

    task automatic pulse_fs();
        @(posedge clk); #1 frame_start = 1'b1;
        if (m_pending) begin
            exp_q.push_back(m_pend);
            m_out     = m_pend;
            m_pending = 1'b0;
        end
        @(posedge clk); #1 frame_start = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic check_all(input string tag);
        #1;
        chk({tag, ".outputs"}, 128'(outputs_now()), 128'(m_out));
        chk({tag, ".drop_cnt"}, 128'(drop_cnt), 128'(m_drop));
        chk({tag, ".last_err"}, 128'(last_err), 128'(m_err));
        chk({tag, ".busy"}, 128'(busy), 128'(0));
        chk({tag, ".sdo"}, 128'(sdo), 128'(m_sdo));
        chk({tag, ".frame_valid"}, 128'(frame_valid), 128'(0));
        chk({tag, ".queue"}, 128'(exp_q.size()), 128'(0));
    endtask

    task automatic apply_reset();
        @(posedge clk); #1 reset_n = 1'b0;
        m_pending = 1'b0; m_pend = '0; m_out = '0; m_drop = 0; m_err = 2'd0; m_sdo = 1'b0;
        exp_q.delete();
        @(posedge clk);
        check_all("in_reset");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
    endtask

    // Monitor: every frame_valid cycle must match the oldest expected commit.
    always @(negedge clk) begin : monitor
        frame_t e;
        if (reset_n && frame_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_commit", 128'(exp_q.size()), 128'(1));
            end else begin
                e = exp_q.pop_front();
                chk("commit", 128'(outputs_now()), 128'(e));
            end
        end
    end

    initial begin
        frame_t f1, fa, fb, fr;
        int kind;
        int sel;
        logic [7:0] bad_hdr;

        reset_n = 1'b0; sck = 1'b0; sdi = 1'b0; load = 1'b0; frame_start = 1'b0;
        m_pending = 1'b0; m_pend = '0; m_out = '0; m_drop = 0; m_err = 2'd0; m_sdo = 1'b0;
        repeat (3) @(posedge clk);
        check_all("reset");
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);

        f1 = '{x1: 10'd100, y1: 10'd200, x2: 10'd300, y2: 10'd400, x3: 10'd500,
               y3: 10'd50, x4: 10'd639, y4: 10'd479, r: 4'hF, g: 4'h0, b: 4'hA};
        send_frame(f1, HEADER);
        pulse_fs();
        check_all("valid_frame");

        send_frame(f1, 8'h5A);
        pulse_fs();
        check_all("bad_header");

        fr = f1; fr.x2 = 10'd640;
        send_frame(fr, HEADER);
        pulse_fs();
        check_all("bad_range");

        send_bits(rand_frame(), HEADER, 60);
        repeat (100) @(posedge clk);
        #1 chk("timeout.busy_mid", 128'(busy), 128'(1));
        repeat (TIMEOUT_CYCLES + 20) @(posedge clk);
        m_err = 2'd3; m_sdo = 1'b0; count_drop();
        check_all("timeout");
        send_frame(rand_frame(), HEADER);
        pulse_fs();
        check_all("after_timeout");

        fa = rand_frame(); fb = rand_frame();
        send_frame(fa, HEADER);
        send_frame(fb, HEADER);
        pulse_fs();
        check_all("overwrite");
        pulse_fs();
        check_all("fs_nothing_pending");

        send_frame(rand_frame(), HEADER);
        send_bits(rand_frame(), HEADER, 70);
        apply_reset();
        check_all("after_reset");
        send_frame(f1, HEADER);
        pulse_fs();
        check_all("post_reset_frame");

        for (int it = 0; it < 10; it++) begin
            kind = int'($urandom_range(0, 3));
            fr = rand_frame();
            if (kind == 2) begin
                bad_hdr = 8'($urandom);
                if (bad_hdr == HEADER) bad_hdr = ~bad_hdr;
                send_frame(fr, bad_hdr);
            end else begin
                if (kind == 3) begin
                    sel = int'($urandom_range(0, 7));
                    case (sel)
                        0: fr.x1 = 10'($urandom_range(X_MAX, 1023));
                        1: fr.y1 = 10'($urandom_range(Y_MAX, 1023));
                        2: fr.x2 = 10'($urandom_range(X_MAX, 1023));
                        3: fr.y2 = 10'($urandom_range(Y_MAX, 1023));
                        4: fr.x3 = 10'($urandom_range(X_MAX, 1023));
                        5: fr.y3 = 10'($urandom_range(Y_MAX, 1023));
                        6: fr.x4 = 10'($urandom_range(X_MAX, 1023));
                        default: fr.y4 = 10'($urandom_range(Y_MAX, 1023));
                    endcase
                end
                send_frame(fr, HEADER);
            end
            if ($urandom_range(0, 1) == 1) pulse_fs();
            check_all("random");
        end
        pulse_fs();
        check_all("final");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
